// File: rtl/dcfifo_pkg.sv
// Shared helpers for both sides of the dual-clock FIFO: pointer width and Gray conversion.
// Callers zero-extend narrower pointers into gvec_t and truncate the result back.
package dcfifo_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gvec_t;

  // Pointer carries one extra wrap bit above the BRAM address.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic gvec_t bin2gray(input gvec_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero high bits stay zero through the prefix XOR, so any narrower width works.
  function automatic gvec_t gray2bin(input gvec_t g);
    gvec_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/dcfifo_rd_ctrl_if.sv
// First-word-fall-through output stream of the FIFO read side.
interface dcfifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/dcfifo_out_skid.sv
// Two-entry output buffer that absorbs the BRAM read latency; entry 0 is the head.
module dcfifo_out_skid #(
  parameter int DATA_WIDTH = 32
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [1:0]            count_q, count_d, kept;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic                  valid_q;

  // Pop first, then the captured word lands in the first free slot.
  always_comb begin
    kept   = count_q - {1'b0, pop_i};
    ent0_d = pop_i ? ent1_q : ent0_q;
    ent1_d = ent1_q;
    if (cap_i) begin
      if (kept == 2'd0) ent0_d = cap_data_i;
      else              ent1_d = cap_data_i;
    end
    count_d = kept + {1'b0, cap_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      valid_q <= (count_d != 2'd0);
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign data_o  = ent0_q;

endmodule

// File: rtl/dcfifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO (read clock domain only).
// Optional macro DCFIFO_RD_OCCUPANCY_EN adds a registered rd_occupancy output.
module dcfifo_rd_ctrl
  import dcfifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 512,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  dcfifo_rd_ctrl_if.master      out_if,
  output logic                  empty
`ifdef DCFIFO_RD_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH+1:0] rd_occupancy
`endif
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);

  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_gray_q, rd_gray_d;
  logic             in_flight_q;
  logic [1:0]       count;
  logic [2:0]       occ_next;
  logic             pop, issue;

  assign empty    = (rd_gray_q == wr_ptr_gray_sync);
  assign pop      = out_if.out_valid & out_if.out_ready;
  // Buffer slots committed after this edge; keep at most two words owned.
  assign occ_next = {1'b0, count} + {2'b0, in_flight_q} - {2'b0, pop};
  assign issue    = !rst && !empty && (occ_next < 3'd2);

  assign bram_en     = issue;
  assign bram_addr   = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray = rd_gray_q;

  always_comb begin
    rd_bin_d  = issue ? rd_bin_q + PTR_W'(1) : rd_bin_q;
    rd_gray_d = PTR_W'(bin2gray(gvec_t'(rd_bin_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      in_flight_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      in_flight_q <= issue;
    end
  end

  // BRAM output is only meaningful the cycle after an issue.
  dcfifo_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .cap_i      (in_flight_q),
    .cap_data_i (bram_dout),
    .pop_i      (pop),
    .count_o    (count),
    .valid_o    (out_if.out_valid),
    .data_o     (out_if.out_data)
  );

`ifdef DCFIFO_RD_OCCUPANCY_EN
  localparam int OCC_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_bin;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Words still in BRAM plus words already read but not yet popped.
  assign wr_bin = PTR_W'(gray2bin(gvec_t'(wr_ptr_gray_sync)));
  assign occ_d  = {1'b0, wr_bin - rd_bin_q} + OCC_W'(count) + OCC_W'(in_flight_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign rd_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_dcfifo_rd_ctrl.sv
// Directed bench for dcfifo_rd_ctrl: per-cycle vector table on a 512-deep instance,
// plus hand sequences for pointer wrap (4-deep instance) and mid-stream reset.
module tb_dcfifo_rd_ctrl;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // 512-deep instance
  logic [9:0]  wgray, rgray;
  logic        en, emp;
  logic [8:0]  addr;
  logic [31:0] dout = 32'hDEADBEEF;
  logic [31:0] mem [512];
  dcfifo_rd_ctrl_if #(.DATA_WIDTH(DW)) ifm ();
`ifdef DCFIFO_RD_OCCUPANCY_EN
  logic [10:0] occ;
`endif

  dcfifo_rd_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(512)) dut (
    .clk(clk), .rst(rst), .wr_ptr_gray_sync(wgray), .rd_ptr_gray(rgray),
    .bram_en(en), .bram_addr(addr), .bram_dout(dout), .out_if(ifm), .empty(emp)
`ifdef DCFIFO_RD_OCCUPANCY_EN
    , .rd_occupancy(occ)
`endif
  );

  always @(posedge clk) if (en) dout <= mem[addr];

  // 4-deep instance for the wrap test
  logic [2:0]  wgray4, rgray4;
  logic        en4, emp4;
  logic [1:0]  addr4;
  logic [31:0] dout4 = 32'hDEADBEEF;
  logic [31:0] mem4 [4];
  dcfifo_rd_ctrl_if #(.DATA_WIDTH(DW)) ifm4 ();
`ifdef DCFIFO_RD_OCCUPANCY_EN
  logic [3:0] occ4;
`endif

  dcfifo_rd_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .wr_ptr_gray_sync(wgray4), .rd_ptr_gray(rgray4),
    .bram_en(en4), .bram_addr(addr4), .bram_dout(dout4), .out_if(ifm4), .empty(emp4)
`ifdef DCFIFO_RD_OCCUPANCY_EN
    , .rd_occupancy(occ4)
`endif
  );

  always @(posedge clk) if (en4) dout4 <= mem4[addr4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] g10(input int n);
    logic [9:0] b;
    b = n[9:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] g3(input int n);
    logic [2:0] b;
    b = n[2:0];
    return b ^ (b >> 1);
  endfunction

  typedef struct {
    int          wr;    // binary write pointer presented this cycle
    logic        rdy;
    logic        en;
    int          addr;
    logic        vld;
    logic [31:0] data;  // compared only when vld is expected
    logic        emp;
    logic [9:0]  rdg;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int wr, input logic rdy, input logic e_en, input int e_addr,
                     input logic e_vld, input logic [31:0] e_data, input logic e_emp,
                     input logic [9:0] e_rdg);
    vec_t v;
    v.wr = wr; v.rdy = rdy; v.en = e_en; v.addr = e_addr;
    v.vld = e_vld; v.data = e_data; v.emp = e_emp; v.rdg = e_rdg;
    vq.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_d[$];
    logic [31:0] got_a[$];
    logic [31:0] got_g[$];
    logic [2:0]  lastg;
    int          wr4;
    int          exp_g[10];
    int          exp_a[10];

    // single word at addr 0, then two 8-word bursts
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[0] = 32'h11;
    for (int i = 1; i <= 8; i++) begin
      mem[i]     = i;
      mem[i + 8] = i;
    end
    for (int i = 0; i < 4; i++) mem4[i] = 32'h0;

    rst = 1'b0;
    wgray = '0; wgray4 = '0;
    ifm.out_ready = 1'b1; ifm4.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst out_valid", 32'(ifm.out_valid), 0);
    check("rst out_data", ifm.out_data, 0);
    check("rst bram_en", 32'(en), 0);
    check("rst rd_ptr_gray", 32'(rgray), 0);
    check("rst empty", 32'(emp), 1);
    check("rst4 out_valid", 32'(ifm4.out_valid), 0);
    check("rst4 rd_ptr_gray", 32'(rgray4), 0);
    @(negedge clk);
    rst = 1'b0;

    //   wr  rdy en addr vld data   emp rdg
    add( 0, 1, 0,  0, 0, 32'h0,  1,  0);
    add( 1, 1, 1,  0, 0, 32'h0,  0,  0);
    add( 1, 1, 0,  1, 0, 32'h0,  1,  1);
    add( 1, 1, 0,  1, 1, 32'h11, 1,  1);
    add( 1, 1, 0,  1, 0, 32'h0,  1,  1);
    add( 9, 1, 1,  1, 0, 32'h0,  0,  1);
    add( 9, 1, 1,  2, 0, 32'h0,  0,  3);
    add( 9, 1, 1,  3, 1, 32'h1,  0,  2);
    add( 9, 1, 1,  4, 1, 32'h2,  0,  6);
    add( 9, 1, 1,  5, 1, 32'h3,  0,  7);
    add( 9, 1, 1,  6, 1, 32'h4,  0,  5);
    add( 9, 1, 1,  7, 1, 32'h5,  0,  4);
    add( 9, 1, 1,  8, 1, 32'h6,  0, 12);
    add( 9, 1, 0,  9, 1, 32'h7,  1, 13);
    add( 9, 1, 0,  9, 1, 32'h8,  1, 13);
    add( 9, 1, 0,  9, 0, 32'h0,  1, 13);
    add(17, 0, 1,  9, 0, 32'h0,  0, 13);
    add(17, 0, 1, 10, 0, 32'h0,  0, 15);
    add(17, 0, 0, 11, 1, 32'h1,  0, 14);
    add(17, 0, 0, 11, 1, 32'h1,  0, 14);
    add(17, 0, 0, 11, 1, 32'h1,  0, 14);
    add(17, 1, 1, 11, 1, 32'h1,  0, 14);
    add(17, 1, 1, 12, 1, 32'h2,  0, 10);
    add(17, 1, 1, 13, 1, 32'h3,  0, 11);
    add(17, 1, 1, 14, 1, 32'h4,  0,  9);
    add(17, 1, 1, 15, 1, 32'h5,  0,  8);
    add(17, 1, 1, 16, 1, 32'h6,  0, 24);
    add(17, 1, 0, 17, 1, 32'h7,  1, 25);
    add(17, 1, 0, 17, 1, 32'h8,  1, 25);
    add(17, 1, 0, 17, 0, 32'h0,  1, 25);

    foreach (vq[i]) begin
      @(negedge clk);
      wgray = g10(vq[i].wr);
      ifm.out_ready = vq[i].rdy;
      #1;
      check($sformatf("row%0d bram_en", i), 32'(en), 32'(vq[i].en));
      check($sformatf("row%0d bram_addr", i), 32'(addr), vq[i].addr);
      check($sformatf("row%0d out_valid", i), 32'(ifm.out_valid), 32'(vq[i].vld));
      check($sformatf("row%0d empty", i), 32'(emp), 32'(vq[i].emp));
      check($sformatf("row%0d rd_ptr_gray", i), 32'(rgray), 32'(vq[i].rdg));
      if (vq[i].vld) check($sformatf("row%0d out_data", i), ifm.out_data, vq[i].data);
    end

    // wrap on the 4-deep instance: writer adds one word every other cycle
    exp_g = '{0, 1, 3, 2, 6, 7, 5, 4, 0, 1};
    exp_a = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    wr4 = 0;
    lastg = rgray4;
    got_g.push_back(32'(rgray4));
    for (int cyc = 0; cyc < 200 && got_d.size() < 10; cyc++) begin
      @(negedge clk);
      if (wr4 < 10 && (cyc % 2) == 0) begin
        mem4[wr4 % 4] = 32'hA0 + wr4;
        wr4++;
        wgray4 = g3(wr4);
      end
      #1;
      if (en4) got_a.push_back(32'(addr4));
      if (ifm4.out_valid && ifm4.out_ready) got_d.push_back(ifm4.out_data);
      if (rgray4 != lastg) begin
        got_g.push_back(32'(rgray4));
        lastg = rgray4;
      end
    end
    check("wrap words received", got_d.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap gray%0d", i), (i < got_g.size()) ? got_g[i] : 32'hFFFF, exp_g[i]);
      check($sformatf("wrap addr%0d", i), (i < got_a.size()) ? got_a[i] : 32'hFFFF, exp_a[i]);
      check($sformatf("wrap data%0d", i), (i < got_d.size()) ? got_d[i] : 32'hFFFF, 32'hA0 + i);
    end

    // reset with one word buffered and the next one in flight
    mem[17] = 32'h55;
    mem[18] = 32'h66;
    @(negedge clk);
    wgray = g10(19);
    ifm.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-rst out_valid", 32'(ifm.out_valid), 1);
    check("pre-rst out_data", ifm.out_data, 32'h55);
    #1 rst = 1'b1;
    #1;
    check("async rst out_valid", 32'(ifm.out_valid), 0);
    check("async rst out_data", ifm.out_data, 0);
    check("async rst rd_ptr_gray", 32'(rgray), 0);
    check("async rst bram_en", 32'(en), 0);
    wgray = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst%0d out_valid", i), 32'(ifm.out_valid), 0);
      check($sformatf("post-rst%0d empty", i), 32'(emp), 1);
      check($sformatf("post-rst%0d bram_en", i), 32'(en), 0);
    end
    mem[0] = 32'h77;
    @(negedge clk);
    wgray = g10(1);
    ifm.out_ready = 1'b1;
    #1;
    check("post-rst issue en", 32'(en), 1);
    check("post-rst issue addr", 32'(addr), 0);
    @(negedge clk);
    #1;
    check("post-rst latency valid", 32'(ifm.out_valid), 0);
    @(negedge clk);
    #1;
    check("post-rst first valid", 32'(ifm.out_valid), 1);
    check("post-rst first data", ifm.out_data, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
